// File: rtl/dem_lane_sched_pkg.sv
// Shared types and lane-search helpers for the dem_lane_sched lane scheduler.
// The helpers honour the lane mask that DEM_SCHED_SKIP_EN enables.
package dem_lane_sched_pkg;

  localparam int LANES  = 8;
  localparam int LANE_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // {found, index} of the lowest enabled lane
  function automatic logic [LANE_W:0] first_lane(input logic [LANES-1:0] mask);
    first_lane = {1'b0, 3'd0};
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask[i]) first_lane = {1'b1, LANE_W'(i)};
    end
  endfunction

  // {found, index} of the lowest enabled lane strictly above cur
  function automatic logic [LANE_W:0] next_lane(input logic [LANES-1:0] mask,
                                                input logic [LANE_W-1:0] cur);
    next_lane = {1'b0, 3'd0};
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask[i] && (LANE_W'(i) > cur)) next_lane = {1'b1, LANE_W'(i)};
    end
  endfunction

endpackage

// File: rtl/dem_lane_sched_dem1_8.sv
// dem1_8: 1-to-8 demultiplexer routing Din to output SD8; all other outputs low.
module dem1_8 (
  input  logic       Din,
  input  logic [2:0] SD8,
  output logic [7:0] Dout
);

  // route the single input bit to the selected output
  always_comb begin
    Dout      = 8'h00;
    Dout[SD8] = Din;
  end

endmodule

// File: rtl/dem_lane_sched.sv
// dem_lane_sched: writes an accepted 8-lane block one lane per cycle to ready destinations.
// Optional macro DEM_SCHED_SKIP_EN: skip lanes cleared in in_mask at zero cycle cost.
module dem_lane_sched
  import dem_lane_sched_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic [LANES-1:0]        in_mask,
  input  logic [LANES-1:0]        lane_ready,
  output logic [LANES-1:0]        lane_we,
  output logic [DATA_W-1:0]       lane_data,
  output logic [LANE_W-1:0]       lane_sel,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int STALL_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  state_t                  state_r, state_s;
  logic [LANES*DATA_W-1:0] data_r;
  logic [LANES-1:0]        mask_r, mask_in_s;
  logic [LANE_W-1:0]       sel_r;
  logic [STALL_W-1:0]      stall_r;
  logic [LANE_W:0]         first_s, next_s;
  logic                    accept_s, timeout_s, issue_s, write_s, last_s;

`ifdef DEM_SCHED_SKIP_EN
  assign mask_in_s = in_mask;
`else
  assign mask_in_s = in_mask | {LANES{1'b1}};
`endif

  assign accept_s  = in_valid && (state_r == ST_IDLE);
  assign first_s   = first_lane(mask_in_s);
  assign next_s    = next_lane(mask_r, sel_r);
  assign last_s    = !next_s[LANE_W];
  assign timeout_s = (TIMEOUT_CYC != 0) && (stall_r == STALL_W'(TIMEOUT_CYC));
  assign issue_s   = (state_r == ST_ISSUE) && !timeout_s;
  assign write_s   = issue_s && lane_ready[sel_r];

  assign lane_sel  = sel_r;
  assign lane_data = (state_r == ST_ISSUE) ? data_r[sel_r*DATA_W +: DATA_W] : {DATA_W{1'b0}};

  dem1_8 u_demux (
    .Din  (write_s),
    .SD8  (sel_r),
    .Dout (lane_we)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  // next-state and status outputs
  always_comb begin
    state_s  = state_r;
    in_ready = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    err      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (accept_s) state_s = first_s[LANE_W] ? ST_ISSUE : ST_DONE;
        else          state_s = ST_IDLE;
      end
      ST_ISSUE: begin
        if (timeout_s) begin
          err     = 1'b1;
          state_s = ST_IDLE;
        end else if (write_s && last_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_s = ST_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // block capture, lane pointer and stall counter; pointer parks at 0 between blocks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r  <= {(LANES*DATA_W){1'b0}};
      mask_r  <= {LANES{1'b0}};
      sel_r   <= {LANE_W{1'b0}};
      stall_r <= {STALL_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            data_r  <= in_data;
            mask_r  <= mask_in_s;
            sel_r   <= first_s[LANE_W-1:0];
            stall_r <= {STALL_W{1'b0}};
          end
        end
        ST_ISSUE: begin
          if (timeout_s) begin
            sel_r   <= {LANE_W{1'b0}};
            stall_r <= {STALL_W{1'b0}};
          end else if (write_s) begin
            sel_r   <= last_s ? {LANE_W{1'b0}} : next_s[LANE_W-1:0];
            stall_r <= {STALL_W{1'b0}};
          end else begin
            stall_r <= stall_r + STALL_W'(1);
          end
        end
        default: begin
          sel_r   <= {LANE_W{1'b0}};
          stall_r <= {STALL_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: doc/dem_lane_sched.md
DEM_LANE_SCHED -- requirements
Module: dem_lane_sched

Interface
REQ-001 Parameter DATA_W, default 8, width of one lane byte/word.
REQ-002 Parameter TIMEOUT_CYC, default 15, max consecutive stall cycles before abort; 0 disables timeout.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  source offers an 8-lane block.
REQ-006 in_ready  output  1  block accepted when in_valid & in_ready.
REQ-007 in_data  input  8*DATA_W  lane k data at bits [k*DATA_W +: DATA_W].
REQ-008 in_mask  input  8  lane enables; sampled only with DEM_SCHED_SKIP_EN.
REQ-009 lane_ready  input  8  per-destination ready.
REQ-010 lane_we  output  8  one-hot write strobe to destination lane_sel.
REQ-011 lane_data  output  DATA_W  data for current lane.
REQ-012 lane_sel  output  3  current lane index, also drives the demux select.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  one-cycle pulse after the last lane write.
REQ-015 err  output  1  one-cycle pulse on timeout abort.

Function
REQ-016 FSM states: IDLE, ISSUE, DONE.
REQ-017 IDLE: in_ready=1, no strobes; on accept, register in_data (and in_mask) and go to ISSUE with lane_sel set to the first enabled lane (lane 0 without macro).
REQ-018 ISSUE: lane_data = registered lane[lane_sel]; lane_we = onehot(lane_sel) when lane_ready[lane_sel]=1, else 0; combinational from registered state.
REQ-019 A write occurs when lane_we is nonzero; the next lane (next enabled with macro) is selected the following cycle.
REQ-020 A write on lane 7, or on the last enabled lane, moves to DONE; DONE asserts done for one cycle, then returns to IDLE.
REQ-021 in_ready=0 in ISSUE and DONE; a new block is accepted earliest the cycle after done.
REQ-022 Minimum latency with all lanes ready: accept in cycle N, writes in N+1..N+8, done in N+9.
REQ-023 Stall counter clears on every write and on entry to ISSUE; it increments each ISSUE cycle without a write.
REQ-024 When the stall counter reaches TIMEOUT_CYC (nonzero), the block pulses err, issues no strobe that cycle, and returns to IDLE discarding remaining lanes; done is not asserted.
REQ-025 lane_ready for any lane other than lane_sel is ignored.
REQ-026 At most one lane_we bit is ever high.

Reset
REQ-027 rst_n low forces IDLE asynchronously, including mid-block; no completion occurs for the aborted block.
REQ-028 Reset values: lane_we=0, lane_sel=0, lane_data=0, busy=0, done=0, err=0, stall counter=0, in_ready=1 after reset deasserts.

Configuration
REQ-029 Macro DEM_SCHED_SKIP_EN.
- Defined: masked-off lanes are skipped with no cycle spent; an all-zero mask goes IDLE->DONE directly (done one cycle after accept).
- Undefined: in_mask is ignored and all 8 lanes are always written in order 0..7.

Structure
REQ-030 Shared package holds the FSM state enum, lane count constant (8), and lane-index width (3).
REQ-031 lane_we is generated by one instance of the existing dem1_8 1-to-8 demux: Din = ISSUE & lane_ready[lane_sel], SD8 = lane_sel; no other sub-modules.

Verification
REQ-032 Reset, then block 0x0706050403020100 with all lanes ready -> lane_we 0x01,0x02..0x80 on consecutive cycles, lane_data 0x00..0x07, done at accept+9.
REQ-033 Hold lane_ready[3]=0 for 4 cycles -> lane_we stays 0 for 4 cycles at lane_sel=3; the write resumes on release; done at accept+13.
REQ-034 TIMEOUT_CYC=15, lane_ready[5] stuck low -> err pulse after 15 stall cycles at lane 5; no done; in_ready=1 the next cycle.
REQ-035 Assert rst_n low during the lane 4 write -> all outputs 0 immediately and busy=0; the next block starts at lane 0.
REQ-036 With DEM_SCHED_SKIP_EN, mask 0x81 -> writes only to lanes 0 and 7 on consecutive cycles; mask 0x00 -> done at accept+1 with no writes.
